// File: rtl/pc_pkg.sv
// Shared types and default sizes for the 3BC program-counter / fetch-control stage.
package pc_pkg;

    localparam int PC_W_DEF       = 10;
    localparam int LINK_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_state_t;

    typedef logic [PC_W_DEF-1:0] pc_t;

endpackage

// File: rtl/link_stack.sv
// Small LIFO of return addresses for branch-and-link / return.
// The pointer saturates at 0 and DEPTH: pushes when full and pops when empty are ignored.
module link_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] ptr_reg;
    logic [W-1:0]     mem_reg [DEPTH];

    assign full  = (ptr_reg == PTR_W'(DEPTH));
    assign empty = (ptr_reg == '0);

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            ptr_reg <= '0;
        end else if (push && !full) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
        end else if (pop && !empty) begin
            ptr_reg <= ptr_reg - PTR_W'(1);
        end
    end

    // Entry gi is written when the pointer sits at gi, i.e. it becomes the new top.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && !full && (ptr_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_reg == PTR_W'(i + 1)) begin
                top = mem_reg[i];
            end
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch-control stage: IDLE->RUN->DONE sequencing, PC+1, relative branches,
// bnzl/return via link_stack. Optional RUN-cycle counter enabled by PC_CYCLE_COUNT_EN.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LINK_DEPTH = LINK_DEPTH_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            Halt,
    input  logic            BranchRelEn,
    input  logic            BranchFlag,
    input  logic            LinkEn,
    input  logic            RetEn,
    input  logic [PC_W-1:0] Offset,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic            StackErr
`ifdef PC_CYCLE_COUNT_EN
    ,
    output logic [15:0]     CycleCount
`endif
);

    pc_state_t       state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            err_reg, err_next;
    logic [PC_W-1:0] pc_inc;
    logic            start_accept;
    logic            stk_push, stk_pop, stk_clear;
    logic [PC_W-1:0] stk_top;
    logic            stk_full, stk_empty;

    assign pc_inc = pc_reg + PC_W'(1);

    link_stack #(
        .DEPTH (LINK_DEPTH),
        .W     (PC_W)
    ) u_link_stack (
        .clk       (Clk),
        .srst      (Reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .clear     (stk_clear),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        err_next     = err_reg;
        stk_push     = 1'b0;
        stk_pop      = 1'b0;
        stk_clear    = 1'b0;
        start_accept = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (Start) begin
                    start_accept = 1'b1;
                    pc_next      = StartAddr;
                    stk_clear    = 1'b1;
                    err_next     = 1'b0;
                    state_next   = RUN;
                end
            end
            RUN: begin
                if (Halt) begin
                    state_next = DONE;
                end else if (RetEn) begin
                    if (!stk_empty) begin
                        pc_next = stk_top;
                        stk_pop = 1'b1;
                    end else begin
                        err_next = 1'b1;
                        pc_next  = pc_inc;
                    end
                end else if (BranchRelEn && BranchFlag) begin
                    // Two's-complement add gives the signed offset modulo 2^PC_W.
                    pc_next = pc_reg + Offset;
                    if (LinkEn) begin
                        if (stk_full) begin
                            err_next = 1'b1;
                        end else begin
                            stk_push = 1'b1;
                        end
                    end
                end else begin
                    pc_next = pc_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ProgCtr  = pc_reg;
    assign Running  = (state_reg == RUN);
    assign Done     = (state_reg == DONE);
    assign StackErr = err_reg;

`ifdef PC_CYCLE_COUNT_EN
    logic [15:0] cnt_reg, cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (start_accept) begin
            cnt_next = '0;
        end else if ((state_reg == RUN) && (cnt_reg != 16'hFFFF)) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign CycleCount = cnt_reg;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl (PC_W=10, LINK_DEPTH=4).
// CycleCount checks are compiled in when PC_CYCLE_COUNT_EN is defined.
module tb_pc_fetch_ctrl;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            halt;
    logic            br_en;
    logic            br_flag;
    logic            link_en;
    logic            ret_en;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] prog_ctr;
    logic            running;
    logic            done;
    logic            stack_err;
`ifdef PC_CYCLE_COUNT_EN
    logic [15:0]     cycle_count;
`endif

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(
        .PC_W       (PC_W),
        .LINK_DEPTH (4)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .Start       (start),
        .StartAddr   (start_addr),
        .Halt        (halt),
        .BranchRelEn (br_en),
        .BranchFlag  (br_flag),
        .LinkEn      (link_en),
        .RetEn       (ret_en),
        .Offset      (offset),
        .ProgCtr     (prog_ctr),
        .Running     (running),
        .Done        (done),
        .StackErr    (stack_err)
`ifdef PC_CYCLE_COUNT_EN
        ,
        .CycleCount  (cycle_count)
`endif
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        assert_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic h, input logic be, input logic bf,
                       input logic le, input logic re, input int off);
        halt    = h;
        br_en   = be;
        br_flag = bf;
        link_en = le;
        ret_en  = re;
        offset  = PC_W'(off);
    endtask

    task automatic step_pc(input string tag, input int exp_pc);
        tick();
        check_eq(tag, int'(prog_ctr), exp_pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0;
        ctl(0, 0, 0, 0, 0, 0);
        tick(); tick();
        check_eq("reset_pc", int'(prog_ctr), 0);
        check_eq("reset_running", int'(running), 0);
        check_eq("reset_done", int'(done), 0);
        check_eq("reset_err", int'(stack_err), 0);
`ifdef PC_CYCLE_COUNT_EN
        check_eq("reset_count", int'(cycle_count), 0);
`endif

        rst = 1'b0;
        step_pc("idle_hold", 0);

        start = 1'b1; start_addr = 10'd5;
        step_pc("start_pc", 5);
        check_eq("start_running", int'(running), 1);
        start = 1'b0;
        step_pc("inc_6", 6);
        step_pc("inc_7", 7);
        step_pc("inc_8", 8);
`ifdef PC_CYCLE_COUNT_EN
        check_eq("count_3", int'(cycle_count), 3);
`endif

        ctl(0, 1, 1, 0, 0, 392);  step_pc("br_to_400", 400);
        ctl(0, 1, 1, 0, 0, -370); step_pc("br_neg_370", 30);
        ctl(0, 1, 1, 0, 0, 370);  step_pc("br_back_400", 400);
        ctl(0, 1, 0, 0, 0, -370); step_pc("br_not_taken", 401);
        ctl(0, 1, 1, 0, 0, 622);  step_pc("br_to_1023", 1023);
        ctl(0, 0, 0, 0, 0, 0);    step_pc("wrap_to_0", 0);
        check_eq("wrap_err", int'(stack_err), 0);

        ctl(0, 1, 1, 0, 0, 10);   step_pc("br_to_10", 10);
        ctl(0, 1, 1, 1, 0, 20);   step_pc("bnzl_30", 30);
        ctl(0, 0, 0, 0, 1, 0);    step_pc("ret_11", 11);
        check_eq("ret_err0", int'(stack_err), 0);
        ctl(0, 0, 0, 0, 1, 0);    step_pc("ret_empty_12", 12);
        check_eq("ret_empty_err", int'(stack_err), 1);
        ctl(0, 1, 0, 1, 0, 20);   step_pc("link_untaken_13", 13);
        ctl(0, 0, 0, 0, 1, 0);    step_pc("ret_empty_14", 14);
        ctl(0, 1, 1, 0, 0, 36);   step_pc("br_to_50", 50);

        ctl(1, 0, 0, 0, 0, 0);    step_pc("halt_pc", 50);
        check_eq("halt_done", int'(done), 1);
        check_eq("halt_running", int'(running), 0);
`ifdef PC_CYCLE_COUNT_EN
        check_eq("halt_count", int'(cycle_count), 17);
`endif
        ctl(0, 0, 0, 0, 0, 0);    step_pc("done_hold", 50);
        check_eq("done_hold_done", int'(done), 1);
`ifdef PC_CYCLE_COUNT_EN
        check_eq("done_count_hold", int'(cycle_count), 17);
`endif

        start = 1'b1; start_addr = 10'd100;
        step_pc("restart_pc", 100);
        start = 1'b0;
        check_eq("restart_running", int'(running), 1);
        check_eq("restart_err_clr", int'(stack_err), 0);
`ifdef PC_CYCLE_COUNT_EN
        check_eq("restart_count", int'(cycle_count), 0);
`endif
        ctl(0, 1, 1, 1, 0, 10);
        step_pc("push1", 110);
        step_pc("push2", 120);
        step_pc("push3", 130);
        step_pc("push4", 140);
        check_eq("push4_err", int'(stack_err), 0);
        step_pc("push5_full", 150);
        check_eq("push5_err", int'(stack_err), 1);
        ctl(0, 0, 0, 0, 1, 0);
        step_pc("pop_131", 131);
        step_pc("pop_121", 121);
        step_pc("pop_111", 111);
        step_pc("pop_101", 101);
        ctl(0, 1, 1, 1, 0, 10);   step_pc("bnzl_111", 111);
        ctl(0, 1, 1, 1, 1, 10);   step_pc("ret_priority_102", 102);
        ctl(0, 0, 0, 0, 1, 0);    step_pc("ret_empty_103", 103);
        ctl(0, 0, 0, 0, 0, 0);
        start = 1'b1; start_addr = 10'd7;
        step_pc("start_ignored", 104);
        check_eq("start_ignored_run", int'(running), 1);

        rst = 1'b1; halt = 1'b1;
        step_pc("midrun_reset_pc", 0);
        check_eq("midrun_reset_running", int'(running), 0);
        check_eq("midrun_reset_done", int'(done), 0);
        check_eq("midrun_reset_err", int'(stack_err), 0);
`ifdef PC_CYCLE_COUNT_EN
        check_eq("midrun_reset_count", int'(cycle_count), 0);
`endif
        rst = 1'b0; start = 1'b0; halt = 1'b0;
        step_pc("post_reset_idle", 0);
        check_eq("post_reset_running", int'(running), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
